// File: rtl/ysyx_22040127_seq_divider.sv
// Multi-cycle radix-2 restoring divider for RV64M div/divu/rem/remu.
// The divider takes an operand pair through a valid/ready handshake. It
// produces one quotient bit per cycle and holds the result until it is
// acknowledged. Signed operands are divided as magnitudes, and the signs
// are applied to the result in a separate cycle.
module ysyx_22040127_seq_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            div_signed,
    input  logic            div_valid,
    input  logic            div_ack,
    input  logic            flush,
    output logic            div_ready,
    output logic [1:0]      div_state,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10,
        DONE = 2'b11
    } state_t;

    // Operand context captured on accept
    typedef struct packed {
        logic [XLEN-1:0] dvd;    // |dividend|, shifted out MSB first
        logic [XLEN-1:0] dvs;    // |divisor|
        logic            neg_q;
        logic            neg_r;
    } op_t;

    state_t          state, state_nxt;
    op_t             op;
    logic [XLEN-1:0] r;          // partial remainder, always < |divisor| (or a dividend prefix when divisor=0)
    logic [XLEN-1:0] q;
    logic [CW-1:0]   cnt;

    logic            accept, last;
    logic            sd, ss;
    logic [XLEN:0]   r_sh;
    logic            ge;
    logic [XLEN-1:0] diff;

    assign accept    = (state == IDLE) && div_valid && !flush;
    assign last      = (cnt == CW'(XLEN-1));
    assign sd        = dividend[XLEN-1];
    assign ss        = divisor[XLEN-1];

    // Shift in the next dividend bit, then attempt the subtraction. When
    // r_sh >= divisor, the difference fits in XLEN bits, so the low bits
    // are enough to form the new remainder.
    assign r_sh      = {r, op.dvd[XLEN-1]};
    assign ge        = (r_sh >= {1'b0, op.dvs});
    assign diff      = r_sh[XLEN-1:0] - op.dvs;

    assign div_ready = (state == DONE);
    assign div_state = state;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; flush wins over div_valid and div_ack
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (flush)     state_nxt = IDLE;
                else if (last) state_nxt = SIGN;
            end
            SIGN: state_nxt = flush ? IDLE : DONE;
            DONE: if (flush || div_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch on accept, iterate in CALC, apply signs in SIGN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op  <= '0;
            r   <= '0;
            q   <= '0;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
        end else if (accept) begin
            op.dvd   <= (div_signed && sd) ? -dividend : dividend;
            op.dvs   <= (div_signed && ss) ? -divisor  : divisor;
            op.neg_q <= div_signed && (sd ^ ss) && (divisor != '0);
            op.neg_r <= div_signed && sd;
            r        <= '0;
            q        <= '0;
            cnt      <= '0;
        end else if (state == CALC && !flush) begin
            op.dvd <= op.dvd << 1;
            r      <= ge ? diff : r_sh[XLEN-1:0];
            q      <= {q[XLEN-2:0], ge};
            cnt    <= cnt + 1'b1;
        end else if (state == SIGN && !flush) begin
            quo <= op.neg_q ? -q : q;
            rem <= op.neg_r ? -r : r;
        end
    end

endmodule
